// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing of the F/D/E pipeline registers for
// taken branches, load-use hazards and the decode-stage HALT instruction.
module pipeline_hazard_ctrl #(
  parameter int BRANCH_PENALTY = 2,
  parameter int MEM_LAT        = 2,
  parameter int REG_ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pcSrcE,
  input  logic                  memReadE,
  input  logic [REG_ADDR_W-1:0] rdE,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic                  useRs1D,
  input  logic                  useRs2D,
  input  logic                  haltD,
  input  logic                  resume,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  flushD,
  output logic                  flushE,
  output logic                  halted
);
  localparam int MAXL = (BRANCH_PENALTY > MEM_LAT) ? BRANCH_PENALTY : MEM_LAT;
  localparam int CW   = $clog2(MAXL) + 1;
  typedef enum logic [1:0] {RUN, FLUSH, LDSTALL, HALT} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hazard;
  assign hazard = memReadE & (rdE != '0) &
                  ((useRs1D & (rs1D == rdE)) | (useRs2D & (rs2D == rdE)));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stallF  = 1'b0;
    stallD  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    halted  = 1'b0;
    case (state_q)
      RUN: begin
        if (pcSrcE) begin
          flushD = 1'b1;
          flushE = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            state_d = FLUSH;
            cnt_d   = CW'(BRANCH_PENALTY - 1);
          end
        end else if (hazard) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
          if (MEM_LAT > 1) begin
            state_d = LDSTALL;
            cnt_d   = CW'(MEM_LAT - 1);
          end
        end else if (haltD) begin
          stallF  = 1'b1;
          stallD  = 1'b1;
          flushE  = 1'b1;
          state_d = HALT;
        end
      end
      FLUSH: begin
        flushD  = 1'b1;
        flushE  = 1'b1;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? RUN : FLUSH;
      end
      LDSTALL: begin
        stallF  = 1'b1;
        stallD  = 1'b1;
        flushE  = 1'b1;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? RUN : LDSTALL;
      end
      default: begin
        stallF  = 1'b1;
        stallD  = 1'b1;
        flushE  = 1'b1;
        halted  = 1'b1;
        state_d = resume ? RUN : HALT;
      end
    endcase
  end
endmodule
